jt10_adpcm_seq: RTL and testbench

- Parametrised ADPCM-A channel sequencer: successor to the fixed 6-channel ADPCM-A driver front end.
- Time-multiplexes N channels over one shared ROM port and one shared decoder.
- Owns per-channel start/end/current address, key-on/off, end flags and nibble fetch timing; optional per-channel loop mode.
- Sits between the MMR register block and the ADPCM decoder/gain/accumulator chain.

---
 rtl/jt10_adpcm_seq.sv | 182 ++++++++++++++++++
 tb/tb_jt10_adpcm_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcm_seq.sv
// ADPCM-A channel sequencer: N time-multiplexed channels, one ROM port.
// Optional loop mode via JT10_ADPCMA_LOOP_EN.
module jt10_adpcm_seq #(
    parameter int CH   = 6,
    parameter int CHW  = 3,
    parameter int AW   = 24,
    parameter int TOPW = 16
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [TOPW-1:0] addr_in,
    input  logic [CHW-1:0]  addr_ch,
    input  logic            up_start,
    input  logic            up_end,
    input  logic [CH:0]     aon_cmd,
    input  logic            up_aon,
    input  logic [CH-1:0]   loop_en,
    input  logic [CH-1:0]   clr_flags,
    output logic [CH-1:0]   cur_ch,
    output logic [AW-1:0]   addr,
    output logic            sel,
    output logic            roe_n,
    output logic            decon,
    output logic            clr,
    output logic [CH-1:0]   flags,
    output logic [CH-1:0]   busy
);
    localparam int LW = AW - TOPW;

    typedef enum logic [1:0] {
        IDLE, START, RUN, LOOP
    } st_t;

    st_t             st      [CH];
    logic [AW:0]     cnt     [CH];
    logic [TOPW-1:0] start_r [CH];
    logic [TOPW-1:0] end_r   [CH];
    logic [CH-1:0]   pend_on, pend_off;

    logic [CH-1:0]   ring_nx;
    logic [CHW-1:0]  sc;
    logic [AW:0]     start_nib, end_nib;
    logic [CH-1:0]   cons, on_set, off_set, fset;

    st_t             st_nx;
    logic [AW:0]     cnt_nx;
    logic [AW:0]     o_cnt;
    logic            o_roe_n, o_decon, o_clr;

`ifndef JT10_ADPCMA_LOOP_EN
    logic unused_loop;
    assign unused_loop = ^loop_en;
`endif

    assign ring_nx = {cur_ch[CH-2:0], cur_ch[CH-1]};

    always_comb begin
        sc = '0;
        for (int i = 0; i < CH; i++)
            if (ring_nx[i]) sc = CHW'(i);
    end

    assign start_nib = {start_r[sc], {LW{1'b0}}, 1'b0};
    assign end_nib   = {end_r[sc],   {LW{1'b1}}, 1'b1};

    assign cons    = cen ? ring_nx : '0;
    assign on_set  = (up_aon && !aon_cmd[CH]) ? aon_cmd[CH-1:0] : '0;
    assign off_set = (up_aon &&  aon_cmd[CH]) ? aon_cmd[CH-1:0] : '0;

    // Next state of the channel owning the upcoming slot
    always_comb begin
        st_nx  = st[sc];
        cnt_nx = cnt[sc];
        fset   = '0;
        if (pend_off[sc]) begin
            st_nx = IDLE;
        end else if (pend_on[sc]) begin
            st_nx  = START;
            cnt_nx = start_nib;
        end else begin
            unique case (st[sc])
                IDLE: st_nx = IDLE;
                LOOP: st_nx = START;
                START, RUN: begin
                    st_nx  = RUN;
                    cnt_nx = cnt[sc] + 1'b1;
                    if (cnt[sc] == end_nib) begin
                        fset[sc] = 1'b1;
`ifdef JT10_ADPCMA_LOOP_EN
                        if (loop_en[sc]) begin
                            st_nx  = LOOP;
                            cnt_nx = start_nib;
                        end else begin
                            st_nx = IDLE;
                        end
`else
                        st_nx = IDLE;
`endif
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_decon = 1'b0;
        o_clr   = 1'b0;
        o_roe_n = 1'b1;
        o_cnt   = cnt[sc];
        if (pend_off[sc]) begin
            o_clr = 1'b0;
        end else if (pend_on[sc]) begin
            o_clr = 1'b1;
            o_cnt = start_nib;
        end else begin
            unique case (st[sc])
                IDLE: o_clr = 1'b0;
                LOOP: o_clr = 1'b1;
                START, RUN: begin
                    o_decon = 1'b1;
                    o_roe_n = cnt[sc][0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch <= CH'(1);
            addr   <= '0;
            sel    <= 1'b0;
            roe_n  <= 1'b1;
            decon  <= 1'b0;
            clr    <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else if (cen) begin
            cur_ch  <= ring_nx;
            st[sc]  <= st_nx;
            cnt[sc] <= cnt_nx;
            addr    <= o_cnt[AW:1];
            sel     <= o_cnt[0];
            roe_n   <= o_roe_n;
            decon   <= o_decon;
            clr     <= o_clr;
        end
    end

    // A strobe landing in the consuming clock keeps its bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_on  <= '0;
            pend_off <= '0;
            flags    <= '0;
        end else begin
            pend_on  <= (pend_on  & ~cons) | on_set;
            pend_off <= (pend_off & ~cons) | off_set;
            flags    <= (flags & ~clr_flags) | (cen ? fset : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                start_r[i] <= '0;
                end_r[i]   <= '0;
            end
        end else if (int'(addr_ch) < CH) begin
            if (up_start) start_r[addr_ch] <= addr_in;
            if (up_end)   end_r[addr_ch]   <= addr_in;
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++)
            busy[i] = (st[i] != IDLE);
    end

endmodule

// File: tb/tb_jt10_adpcm_seq.sv
// Scoreboard bench for jt10_adpcm_seq with a behavioural channel model.
// Loop-mode expectations follow JT10_ADPCMA_LOOP_EN when defined.
module tb_jt10_adpcm_seq;
    localparam int CH   = 6;
    localparam int CHW  = 3;
    localparam int AW   = 24;
    localparam int TOPW = 16;
    localparam int LW   = AW - TOPW;

    logic            clk = 0;
    logic            rst = 1;
    logic            cen = 0;
    logic [TOPW-1:0] addr_in = '0;
    logic [CHW-1:0]  addr_ch = '0;
    logic            up_start = 0, up_end = 0, up_aon = 0;
    logic [CH:0]     aon_cmd = '0;
    logic [CH-1:0]   loop_en = '0, clr_flags = '0;
    logic [CH-1:0]   cur_ch, flags, busy;
    logic [AW-1:0]   addr;
    logic            sel, roe_n, decon, clr;

    jt10_adpcm_seq #(.CH(CH), .CHW(CHW), .AW(AW), .TOPW(TOPW)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .addr_in(addr_in), .addr_ch(addr_ch),
        .up_start(up_start), .up_end(up_end),
        .aon_cmd(aon_cmd), .up_aon(up_aon),
        .loop_en(loop_en), .clr_flags(clr_flags),
        .cur_ch(cur_ch), .addr(addr), .sel(sel),
        .roe_n(roe_n), .decon(decon), .clr(clr),
        .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] cur;
        logic [AW-1:0] a;
        logic          s, rn, dc, cl, ck;
        logic [CH-1:0] fl, bz;
    } exp_t;

    exp_t q[$];
    int ncmp = 0;
    int nerr = 0;

    // Reference model: per channel a play pointer in nibble units
    logic [TOPW-1:0] m_start [CH];
    logic [TOPW-1:0] m_end   [CH];
    logic [AW:0]     m_pos   [CH];
    bit              m_play  [CH];
    bit              m_clrn  [CH];
    logic [CH-1:0]   m_on, m_off, m_flags, m_cur;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_start[i] = '0; m_end[i] = '0; m_pos[i] = '0;
            m_play[i] = 0; m_clrn[i] = 0;
        end
        m_on = '0; m_off = '0; m_flags = '0; m_cur = CH'(1);
        q.delete();
    endtask

    task automatic model_edge();
        exp_t e;
        logic [CH-1:0] fset, cons;
        logic [AW:0] sn, en;
        int c;
        fset = '0; cons = '0; c = 0;
        e = '{cur: '0, a: '0, s: 0, rn: 1, dc: 0, cl: 0, ck: 0, fl: '0, bz: '0};
        if (cen) begin
            m_cur = {m_cur[CH-2:0], m_cur[CH-1]};
            for (int i = 0; i < CH; i++) if (m_cur[i]) c = i;
            cons[c] = 1'b1;
            sn = {m_start[c], {LW{1'b0}}, 1'b0};
            en = {m_end[c], {LW{1'b1}}, 1'b1};
            e.cur = m_cur;
            if (m_off[c]) begin
                m_play[c] = 0; m_clrn[c] = 0;
            end else if (m_on[c]) begin
                m_play[c] = 1; m_clrn[c] = 0; m_pos[c] = sn;
                e.cl = 1; e.ck = 1; e.a = sn[AW:1]; e.s = 0;
            end else if (m_play[c] && m_clrn[c]) begin
                m_clrn[c] = 0;
                e.cl = 1; e.ck = 1;
                e.a = m_pos[c][AW:1]; e.s = m_pos[c][0];
            end else if (m_play[c]) begin
                e.dc = 1; e.ck = 1;
                e.a = m_pos[c][AW:1]; e.s = m_pos[c][0];
                e.rn = m_pos[c][0];
                if (m_pos[c] == en) begin
                    fset[c] = 1'b1;
`ifdef JT10_ADPCMA_LOOP_EN
                    if (loop_en[c]) begin
                        m_pos[c] = sn; m_clrn[c] = 1;
                    end else m_play[c] = 0;
`else
                    m_play[c] = 0;
`endif
                end else begin
                    m_pos[c] = m_pos[c] + 1'b1;
                end
            end
        end
        m_on  = m_on  & ~cons;
        m_off = m_off & ~cons;
        if (up_aon) begin
            if (aon_cmd[CH]) m_off = m_off | aon_cmd[CH-1:0];
            else             m_on  = m_on  | aon_cmd[CH-1:0];
        end
        if (int'(addr_ch) < CH) begin
            if (up_start) m_start[addr_ch] = addr_in;
            if (up_end)   m_end[addr_ch]   = addr_in;
        end
        m_flags = (m_flags & ~clr_flags) | fset;
        if (cen) begin
            e.fl = m_flags;
            for (int i = 0; i < CH; i++) e.bz[i] = m_play[i];
            q.push_back(e);
        end
    endtask

    // Monitor: one expected entry per cen edge
    initial begin
        exp_t e;
        bit took;
        forever begin
            @(posedge clk);
            took = cen && !rst;
            #1;
            if (took) begin
                ncmp++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL slot: no expected entry at %0t", $time);
                end else begin
                    e = q.pop_front();
                    if (cur_ch !== e.cur || roe_n !== e.rn ||
                        decon !== e.dc || clr !== e.cl ||
                        flags !== e.fl || busy !== e.bz ||
                        (e.ck && (addr !== e.a || sel !== e.s))) begin
                        nerr++;
                        $display("FAIL slot t=%0t got cur=%h a=%h s=%b rn=%b dc=%b cl=%b fl=%h bz=%h want cur=%h a=%h s=%b rn=%b dc=%b cl=%b fl=%h bz=%h",
                            $time, cur_ch, addr, sel, roe_n, decon, clr, flags, busy,
                            e.cur, e.a, e.s, e.rn, e.dc, e.cl, e.fl, e.bz);
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
        ncmp++;
        if (act !== ex) begin
            nerr++;
            $display("FAIL %s got %h want %h", nm, act, ex);
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        up_start = 0; up_end = 0; up_aon = 0;
    endtask

    task automatic run(int n, int dens);
        repeat (n) begin
            cen = ($urandom_range(0, 3) < dens);
            step();
        end
    endtask

    task automatic wr(bit is_end, int ch, logic [TOPW-1:0] v);
        addr_ch = CHW'(ch); addr_in = v;
        up_start = !is_end; up_end = is_end;
        cen = $urandom_range(0, 1);
        step();
    endtask

    task automatic aon(logic [CH:0] cmd, bit c);
        aon_cmd = cmd; up_aon = 1; cen = c;
        step();
    endtask

    task automatic play_out(int ch, int maxc);
        int n = 0;
        while ((m_play[ch] || m_on[ch]) && n < maxc) begin
            cen = ($urandom_range(0, 3) != 0);
            step(); n++;
        end
        if (m_play[ch] || m_on[ch]) begin
            ncmp++; nerr++;
            $display("FAIL timeout ch%0d after %0d clks", ch, maxc);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cur_ch", 32'(cur_ch), 32'h1);
        chk("rst_roe_n", 32'(roe_n), 32'h1);
        chk("rst_decon", 32'(decon), 32'h0);
        chk("rst_clr", 32'(clr), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 0;
        run(8, 4);

        // basic play on ch2
        wr(0, 2, 16'h0010);
        wr(1, 2, 16'h0010);
        aon(7'h04, 1);
        play_out(2, 20000);
        chk("basic_flag2", 32'(flags[2]), 32'h1);
        chk("basic_busy2", 32'(busy[2]), 32'h0);

        // key-on and key-off pending together on ch0
        aon(7'h01, 0);
        aon(7'h41, 0);
        run(20, 4);
        chk("prio_busy0", 32'(busy[0]), 32'h0);

        // end of sample with clr_flags held on ch0
        wr(0, 0, 16'h0001);
        wr(1, 0, 16'h0001);
        clr_flags = 6'h01;
        aon(7'h01, 1);
        play_out(0, 20000);
        clr_flags = '0;
        run(4, 4);

        // end below start plays through address wrap
        wr(0, 3, 16'hFFFF);
        wr(1, 3, 16'h0000);
        aon(7'h08, 1);
        play_out(3, 30000);
        chk("wrap_flag3", 32'(flags[3]), 32'h1);

        // restart ch5 mid-play; invalid channel writes ignored
        wr(0, 5, 16'h0020);
        wr(1, 5, 16'h0021);
        aon(7'h20, 1);
        wr(0, 6, 16'hAAAA);
        wr(1, 7, 16'h5555);
        begin
            int n = 0;
            while (m_pos[5][AW:1] != 24'h002080 && n < 20000) begin
                cen = 1; step(); n++;
            end
            chk("restart_reach", 32'(m_pos[5][AW:1]), 32'h002080);
        end
        aon(7'h20, 0);
        play_out(5, 20000);

        // loop mode on ch1 (model applies it only with the macro)
        loop_en = 6'h02;
        wr(0, 1, 16'h0003);
        wr(1, 1, 16'h0003);
        aon(7'h02, 1);
        run(4000, 4);
        aon(7'h42, 1);
        play_out(1, 20000);
        loop_en = '0;

        // randomized traffic
        for (int k = 0; k < 12000; k++) begin
            cen = ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) begin
                addr_ch = CHW'($urandom_range(0, 7));
                addr_in = TOPW'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) up_start = 1;
                else up_end = 1;
            end
            if ($urandom_range(0, 99) == 0) begin
                up_aon = 1;
                aon_cmd = {($urandom_range(0, 3) == 0), CH'($urandom)};
            end
            if ($urandom_range(0, 499) == 0) loop_en = CH'($urandom);
            step();
        end
        clr_flags = '0;
        loop_en = '0;

        // reset while channels play
        wr(0, 0, 16'h0040);
        wr(1, 0, 16'h0041);
        aon(7'h3F, 1);
        run(50, 4);
        #2 rst = 1;
        #1;
        chk("mid_rst_cur_ch", 32'(cur_ch), 32'h1);
        chk("mid_rst_flags", 32'(flags), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_roe_n", 32'(roe_n), 32'h1);
        cen = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
        // start/end were cleared: ch0 plays 0x000000..0x0000FF
        aon(7'h01, 1);
        play_out(0, 20000);
        run(10, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
